// File: rtl/spi_slave_16_pkg.sv
// Shared constants and FSM encoding for the 16-bit SPI link endpoints.
package spi_slave_16_pkg;

  localparam int unsigned SpiWidth      = 16;
  localparam int unsigned SpiSyncStages = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StHold  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_slave_16_if.sv
// SPI pins plus the word-level tx/rx handshake towards the AES core.
interface spi_slave_16_if #(
  parameter int unsigned Width = spi_slave_16_pkg::SpiWidth
) ();

  logic             SCK;
  logic             CS;
  logic             MOSI;
  logic             MISO;
  logic [Width-1:0] tx_data;
  logic             tx_load;
  logic             tx_ready;
  logic [Width-1:0] rx_data;
  logic             rx_valid;
  logic             tx_underrun;
  logic             frame_abort;

  modport slave (
    input  SCK, CS, MOSI, tx_data, tx_load,
    output MISO, tx_ready, rx_data, rx_valid, tx_underrun, frame_abort
  );

  modport master (
    output SCK, CS, MOSI, tx_data, tx_load,
    input  MISO, tx_ready, rx_data, rx_valid, tx_underrun, frame_abort
  );

endinterface

// File: rtl/spi_slave_16_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with registered rise/fall pulse outputs.
module spi_slave_16_sync_edge #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {Stages{ResetVal}};
      prev_q <= ResetVal;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d};
      prev_q <= sync_q[Stages-1];
    end
  end

  assign q    = sync_q[Stages-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave_16.sv
// SPI slave endpoint: one LSB-first word per CS-low frame, oversampled on the system clock.
module spi_slave_16
  import spi_slave_16_pkg::*;
#(
  parameter int unsigned     WIDTH       = SpiWidth,
  parameter int unsigned     SYNC_STAGES = SpiSyncStages,
  parameter logic [WIDTH-1:0] IDLE_WORD  = '0
) (
  input  logic          clock,
  input  logic          reset_n,
  spi_slave_16_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic sck_q, sck_rise, sck_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_q, mosi_rise, mosi_fall;
  logic unused_sync;

  // CS idles high, so its synchronizer resets high to avoid a false edge after reset.
  spi_slave_16_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sck (
    .clock(clock), .reset_n(reset_n), .d(bus.SCK), .q(sck_q), .rise(sck_rise), .fall(sck_fall)
  );
  spi_slave_16_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_cs (
    .clock(clock), .reset_n(reset_n), .d(bus.CS), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );
  spi_slave_16_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
    .clock(clock), .reset_n(reset_n), .d(bus.MOSI), .q(mosi_q), .rise(mosi_rise),
    .fall(mosi_fall)
  );

  assign unused_sync = sck_q ^ mosi_rise ^ mosi_fall;

  spi_state_e       state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
  logic             full_q, full_d;
  logic             rx_valid_q, rx_valid_d, underrun_q, underrun_d, abort_q, abort_d;
  logic             tx_accept, last_rise;

  assign tx_accept = bus.tx_load & ~full_q;
  assign last_rise = sck_rise & (count_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    hold_d     = hold_q;
    full_d     = full_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    abort_d    = 1'b0;

    if (tx_accept) begin
      hold_d = bus.tx_data;
      full_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          count_d = '0;
          rx_sr_d = '0;
          full_d  = 1'b0;
          state_d = StShift;
          // A load coinciding with frame start goes straight to the shifter.
          if (tx_accept) begin
            tx_sr_d = bus.tx_data;
          end else if (full_q) begin
            tx_sr_d = hold_q;
          end else begin
            tx_sr_d    = IDLE_WORD;
            underrun_d = 1'b1;
          end
        end
      end
      StShift: begin
        if (count_q == CntW'(WIDTH)) begin
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          // CS may already be released if it rose alongside the final SCK edge.
          state_d    = cs_q ? StIdle : StHold;
        end else begin
          if (sck_rise) begin
            rx_sr_d = {mosi_q, rx_sr_q[WIDTH-1:1]};
            count_d = count_q + CntW'(1);
          end
          if (sck_fall) begin
            tx_sr_d = {1'b0, tx_sr_q[WIDTH-1:1]};
          end
          if (cs_rise && !last_rise) begin
            abort_d = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StHold: begin
        if (cs_rise) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      hold_q     <= '0;
      full_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      abort_q    <= abort_d;
    end
  end

  assign bus.MISO        = tx_sr_q[0];
  assign bus.tx_ready    = ~full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.frame_abort = abort_q;

endmodule

// File: tb/tb_spi_slave_16.sv
// Directed bench for spi_slave_16: acts as the SPI master and checks word-level results.
module tb_spi_slave_16;

  localparam int Half = 8;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  spi_slave_16_if bus ();

  spi_slave_16 dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rx_cnt = 0, ur_cnt = 0, ab_cnt = 0, valid_cyc = -1000;
  int rise16_cyc = 0;
  int r0, u0, a0;
  logic [31:0] miso_w;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.rx_valid) begin
      rx_cnt    <= rx_cnt + 1;
      valid_cyc <= cyc;
    end
    if (bus.tx_underrun) ur_cnt <= ur_cnt + 1;
    if (bus.frame_abort) ab_cnt <= ab_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic load_tx(input logic [15:0] v);
    bus.tx_data = v;
    bus.tx_load = 1'b1;
    wait_clk(1);
    bus.tx_load = 1'b0;
    wait_clk(2);
  endtask

  task automatic snap();
    r0 = rx_cnt;
    u0 = ur_cnt;
    a0 = ab_cnt;
  endtask

  // Mode-0 master: MOSI set while SCK low, MISO sampled at the rising edge.
  task automatic spi_frame(input logic [31:0] mosi_bits, input int nbits, input bit release_cs,
                           output logic [31:0] miso_bits);
    miso_bits = '0;
    bus.CS = 1'b0;
    wait_clk(Half);
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI = mosi_bits[i];
      wait_clk(Half);
      bus.SCK = 1'b1;
      miso_bits[i] = bus.MISO;
      if (i == 15) rise16_cyc = cyc;
      wait_clk(Half);
      bus.SCK = 1'b0;
    end
    wait_clk(Half);
    if (release_cs) begin
      bus.CS = 1'b1;
      wait_clk(2 * Half);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.SCK     = 1'b0;
    bus.CS      = 1'b1;
    bus.MOSI    = 1'b0;
    bus.tx_data = '0;
    bus.tx_load = 1'b0;
    wait_clk(4);
    check("rst_miso", {31'd0, bus.MISO}, 32'd0);
    check("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    check("rst_rx_data", {16'd0, bus.rx_data}, 32'd0);
    check("rst_pulses", {29'd0, bus.rx_valid, bus.tx_underrun, bus.frame_abort}, 32'd0);
    reset_n = 1'b1;
    wait_clk(4);

    // Normal frame with a preloaded reply.
    load_tx(16'hA5C3);
    check("load_busy", {31'd0, bus.tx_ready}, 32'd0);
    snap();
    spi_frame(32'h0000_1234, 16, 1'b1, miso_w);
    check("t1_rx_data", {16'd0, bus.rx_data}, 32'h1234);
    check("t1_rx_valid_cnt", rx_cnt - r0, 32'd1);
    check("t1_miso", {16'd0, miso_w[15:0]}, 32'hA5C3);
    check("t1_no_underrun", ur_cnt - u0, 32'd0);
    check("t1_no_abort", ab_cnt - a0, 32'd0);
    check("t1_latency", valid_cyc - rise16_cyc, 32'd4);
    check("t1_tx_ready", {31'd0, bus.tx_ready}, 32'd1);

    // Underrun: nothing loaded, idle word returned.
    snap();
    spi_frame(32'h0000_FFFF, 16, 1'b1, miso_w);
    check("t2_miso_idle", {16'd0, miso_w[15:0]}, 32'h0000);
    check("t2_underrun_cnt", ur_cnt - u0, 32'd1);
    check("t2_rx_data", {16'd0, bus.rx_data}, 32'hFFFF);

    // Abort after 9 bits keeps the previous word.
    snap();
    spi_frame(32'h0000_BEEF, 9, 1'b1, miso_w);
    check("t3_abort_cnt", ab_cnt - a0, 32'd1);
    check("t3_rx_kept", {16'd0, bus.rx_data}, 32'hFFFF);
    check("t3_no_valid", rx_cnt - r0, 32'd0);

    // 20 SCK edges: the extra four are ignored and MISO holds the last bit.
    load_tx(16'hBC5A);
    snap();
    spi_frame(32'h000A_0F0F, 20, 1'b1, miso_w);
    check("t4_rx_data", {16'd0, bus.rx_data}, 32'h0F0F);
    check("t4_valid_cnt", rx_cnt - r0, 32'd1);
    check("t4_miso", {16'd0, miso_w[15:0]}, 32'hBC5A);
    check("t4_miso_hold", {28'd0, miso_w[19:16]}, 32'hF);
    check("t4_no_abort", ab_cnt - a0, 32'd0);

    // Second load while full is ignored.
    load_tx(16'h1111);
    load_tx(16'h2222);
    snap();
    spi_frame(32'h0000_5555, 16, 1'b1, miso_w);
    check("t5_miso_first", {16'd0, miso_w[15:0]}, 32'h1111);
    check("t5_no_underrun", ur_cnt - u0, 32'd0);
    check("t5_rx_data", {16'd0, bus.rx_data}, 32'h5555);

    // Reset mid-frame, then a clean frame.
    load_tx(16'h7E81);
    spi_frame(32'h0000_CAFE, 7, 1'b0, miso_w);
    reset_n = 1'b0;
    wait_clk(3);
    check("t6_rst_miso", {31'd0, bus.MISO}, 32'd0);
    check("t6_rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    check("t6_rst_rx_data", {16'd0, bus.rx_data}, 32'd0);
    bus.CS  = 1'b1;
    bus.SCK = 1'b0;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(4);
    snap();
    spi_frame(32'h0000_1357, 16, 1'b1, miso_w);
    check("t6_rx_data", {16'd0, bus.rx_data}, 32'h1357);
    check("t6_valid_cnt", rx_cnt - r0, 32'd1);
    check("t6_underrun_cnt", ur_cnt - u0, 32'd1);
    check("t6_miso_idle", {16'd0, miso_w[15:0]}, 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
